// File: rtl/mac_accum.sv
// mac_accum: sums groups of LEN signed 32-bit products from the multiplier into
// a saturating ACC_W-bit accumulator. Each completed dot-product is presented
// on a valid/ready output register. The input is never stalled, so a result
// that is overwritten before it is accepted raises a sticky overrun flag.
module mac_accum #(
  parameter int LEN   = 8,
  parameter int ACC_W = 40
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [31:0]      in_data,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat,
  input  logic                    out_ready,
  output logic                    overrun,
  output logic [15:0]             count
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  logic [0:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic                    sat_acc;

  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum_sat;
  logic                    sum_clamp;
  logic                    last;

  // An ACC_W+1 bit sum overflowed when its top two bits disagree.
  function automatic logic is_clamp(input logic signed [ACC_W:0] w);
    return w[ACC_W] != w[ACC_W-1];
  endfunction

  // Clamp an ACC_W+1 bit sum into the signed ACC_W-bit range.
  function automatic logic signed [ACC_W-1:0] sat_clamp(input logic signed [ACC_W:0] w);
    if (w[ACC_W] != w[ACC_W-1])
      return w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return w[ACC_W-1:0];
  endfunction

  // A fresh group starts from zero regardless of whatever acc holds.
  assign base      = (state == S_IDLE) ? '0 : acc;
  assign sum_wide  = {base[ACC_W-1], base} + {{(ACC_W-31){in_data[31]}}, in_data};
  assign sum_sat   = sat_clamp(sum_wide);
  assign sum_clamp = is_clamp(sum_wide);
  assign last      = (count == 16'(LEN - 1));

  // Accumulator, product counter and group saturation tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      acc     <= '0;
      count   <= '0;
      sat_acc <= 1'b0;
    end else if (clear) begin
      state   <= S_IDLE;
      acc     <= '0;
      count   <= '0;
      sat_acc <= 1'b0;
    end else if (in_valid) begin
      if (last) begin
        state   <= S_IDLE;
        acc     <= '0;
        count   <= '0;
        sat_acc <= 1'b0;
      end else begin
        state   <= S_ACC;
        acc     <= sum_sat;
        count   <= count + 16'd1;
        sat_acc <= sat_acc | sum_clamp;
      end
    end
  end

  // Output result register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else if (in_valid && last) begin
      // A new result replaces the held one; losing an unaccepted one is an overrun.
      out_valid <= 1'b1;
      out_data  <= sum_sat;
      out_sat   <= sat_acc | sum_clamp;
      if (out_valid && !out_ready)
        overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum: drives five mac_accum instances of different LEN/ACC_W from
// shared stimulus. Directed tables and sequences check specific instances;
// a random phase compares all instances against a group-level model.
module tb_mac_accum;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic iv;
  logic signed [31:0] idata;
  logic rdy;

  logic        ov  [5];
  logic        os  [5];
  logic        ovr [5];
  logic [15:0] cnt [5];
  logic signed [39:0] od0, od1, od3;
  logic signed [32:0] od2;
  logic signed [31:0] od4;

  int checks   = 0;
  int failures = 0;

  int lens [5] = '{4, 2, 4, 1, 5};
  int accw [5] = '{40, 40, 33, 40, 32};

  always #5 clk = ~clk;

  mac_accum #(.LEN(4), .ACC_W(40)) u0 (.clk(clk), .reset_n(rst_n), .clear(clr), .in_valid(iv),
    .in_data(idata), .out_valid(ov[0]), .out_data(od0), .out_sat(os[0]), .out_ready(rdy),
    .overrun(ovr[0]), .count(cnt[0]));
  mac_accum #(.LEN(2), .ACC_W(40)) u1 (.clk(clk), .reset_n(rst_n), .clear(clr), .in_valid(iv),
    .in_data(idata), .out_valid(ov[1]), .out_data(od1), .out_sat(os[1]), .out_ready(rdy),
    .overrun(ovr[1]), .count(cnt[1]));
  mac_accum #(.LEN(4), .ACC_W(33)) u2 (.clk(clk), .reset_n(rst_n), .clear(clr), .in_valid(iv),
    .in_data(idata), .out_valid(ov[2]), .out_data(od2), .out_sat(os[2]), .out_ready(rdy),
    .overrun(ovr[2]), .count(cnt[2]));
  mac_accum #(.LEN(1), .ACC_W(40)) u3 (.clk(clk), .reset_n(rst_n), .clear(clr), .in_valid(iv),
    .in_data(idata), .out_valid(ov[3]), .out_data(od3), .out_sat(os[3]), .out_ready(rdy),
    .overrun(ovr[3]), .count(cnt[3]));
  mac_accum #(.LEN(5), .ACC_W(32)) u4 (.clk(clk), .reset_n(rst_n), .clear(clr), .in_valid(iv),
    .in_data(idata), .out_valid(ov[4]), .out_data(od4), .out_sat(os[4]), .out_ready(rdy),
    .overrun(ovr[4]), .count(cnt[4]));

  function automatic longint act_od(input int i);
    case (i)
      0:       return longint'(od0);
      1:       return longint'(od1);
      2:       return longint'(od2);
      3:       return longint'(od3);
      default: return longint'(od4);
    endcase
  endfunction

  // Reference model: products of the open group, and the held result.
  longint grp [5][$];
  bit     m_ov  [5];
  bit     m_os  [5];
  bit     m_ovr [5];
  longint m_od  [5];

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      grp[i].delete();
      m_ov[i] = 0; m_os[i] = 0; m_ovr[i] = 0; m_od[i] = 0;
    end
  endfunction

  function automatic void model_clock();
    for (int i = 0; i < 5; i++) begin
      longint s, hi, lo;
      bit     sat;
      if (clr) begin
        grp[i].delete();
        m_ov[i] = 0; m_os[i] = 0; m_ovr[i] = 0; m_od[i] = 0;
      end else begin
        if (m_ov[i] && rdy) m_ov[i] = 0;
        if (iv) begin
          grp[i].push_back(longint'(idata));
          if (grp[i].size() == lens[i]) begin
            hi  = (64'sd1 <<< (accw[i] - 1)) - 1;
            lo  = -hi - 1;
            s   = 0;
            sat = 0;
            foreach (grp[i][k]) begin
              s = s + grp[i][k];
              if (s > hi) begin s = hi; sat = 1; end
              else if (s < lo) begin s = lo; sat = 1; end
            end
            if (m_ov[i]) m_ovr[i] = 1;
            m_ov[i] = 1; m_od[i] = s; m_os[i] = sat;
            grp[i].delete();
          end
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit c, input bit v, input int d, input bit r);
    clr = c; iv = v; idata = d; rdy = r;
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic expect_inst(input string nm, input int i, input bit ev, input longint ed,
                             input bit es, input int ec, input bit eovr);
    chk({nm, ".out_valid"}, longint'(ov[i]), longint'(ev));
    if (ev) begin
      chk({nm, ".out_data"}, act_od(i), ed);
      chk({nm, ".out_sat"}, longint'(os[i]), longint'(es));
    end
    chk({nm, ".count"}, longint'(cnt[i]), longint'(ec));
    chk({nm, ".overrun"}, longint'(ovr[i]), longint'(eovr));
  endtask

  task automatic compare_model(input int n);
    for (int i = 0; i < 5; i++) begin
      string nm;
      nm = $sformatf("rand[%0d].u%0d", n, i);
      expect_inst(nm, i, m_ov[i], m_od[i], m_os[i], grp[i].size(), m_ovr[i]);
    end
  endtask

  typedef struct {
    bit     c;
    bit     v;
    int     d;
    bit     r;
    bit     ev;
    longint ed;
    bit     es;
    int     ec;
    bit     eovr;
  } vec_t;

  vec_t tbl [15];

  initial begin
    // Basic group 100,-20,3,7 on LEN=4, then clear mid-group.
    tbl[0]  = '{1, 0,   0, 0, 0,  0, 0, 0, 0};
    tbl[1]  = '{0, 1, 100, 0, 0,  0, 0, 1, 0};
    tbl[2]  = '{0, 1, -20, 0, 0,  0, 0, 2, 0};
    tbl[3]  = '{0, 1,   3, 0, 0,  0, 0, 3, 0};
    tbl[4]  = '{0, 1,   7, 0, 1, 90, 0, 0, 0};
    tbl[5]  = '{0, 0,   0, 0, 1, 90, 0, 0, 0};
    tbl[6]  = '{0, 0,   0, 1, 0,  0, 0, 0, 0};
    tbl[7]  = '{0, 1,   1, 0, 0,  0, 0, 1, 0};
    tbl[8]  = '{0, 1,   2, 0, 0,  0, 0, 2, 0};
    tbl[9]  = '{1, 1,   3, 0, 0,  0, 0, 0, 0};
    tbl[10] = '{0, 1,   1, 0, 0,  0, 0, 1, 0};
    tbl[11] = '{0, 1,   1, 0, 0,  0, 0, 2, 0};
    tbl[12] = '{0, 1,   1, 0, 0,  0, 0, 3, 0};
    tbl[13] = '{0, 1,   1, 0, 1,  4, 0, 0, 0};
    tbl[14] = '{0, 0,   0, 1, 0,  0, 0, 0, 0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    #12;
    for (int i = 0; i < 5; i++) expect_inst($sformatf("reset.u%0d", i), i, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].c, tbl[k].v, tbl[k].d, tbl[k].r);
      step();
      expect_inst($sformatf("tbl[%0d]", k), 0, tbl[k].ev, tbl[k].ed, tbl[k].es, tbl[k].ec, tbl[k].eovr);
    end

    // Back-to-back strobes, LEN=2, always ready.
    drive(1, 0, 0, 1); step();
    drive(0, 1, 5, 1); step(); expect_inst("b2b.p5", 1, 0, 0, 0, 1, 0);
    drive(0, 1, 6, 1); step(); expect_inst("b2b.p6", 1, 1, 11, 0, 0, 0);
    drive(0, 1, 7, 1); step(); expect_inst("b2b.p7", 1, 0, 0, 0, 1, 0);
    drive(0, 1, 8, 1); step(); expect_inst("b2b.p8", 1, 1, 15, 0, 0, 0);
    drive(0, 0, 0, 1); step(); expect_inst("b2b.idle", 1, 0, 0, 0, 0, 0);

    // Saturation, LEN=4, ACC_W=33.
    drive(1, 0, 0, 0); step();
    for (int k = 0; k < 4; k++) begin drive(0, 1, 32'h4000_0000, 0); step(); end
    expect_inst("sat.hi", 2, 1, 64'h0_FFFF_FFFF, 1, 0, 0);
    drive(0, 0, 0, 1); step(); expect_inst("sat.accept", 2, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin drive(0, 1, 1, 0); step(); end
    expect_inst("sat.next", 2, 1, 4, 0, 0, 0);

    // Overrun, LEN=1, not ready.
    drive(1, 0, 0, 0); step();
    drive(0, 1, 9, 0);  step(); expect_inst("ovr.first", 3, 1, 9, 0, 0, 0);
    drive(0, 1, 12, 0); step(); expect_inst("ovr.second", 3, 1, 12, 0, 0, 1);
    drive(0, 0, 0, 1);  step(); expect_inst("ovr.accept", 3, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0);  step(); expect_inst("ovr.clear", 3, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-group with a result pending, LEN=4.
    drive(1, 0, 0, 0); step();
    for (int k = 0; k < 4; k++) begin drive(0, 1, 1, 0); step(); end
    drive(0, 1, 5, 0); step();
    drive(0, 1, 5, 0); step(); expect_inst("arst.before", 0, 1, 4, 0, 2, 0);
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 expect_inst("arst.async", 0, 0, 0, 0, 0, 0);
    chk("arst.out_data", act_od(0), 0);
    #2 rst_n = 1'b1;
    drive(0, 1, 1, 0); step(); expect_inst("arst.p1", 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin drive(0, 1, 1, 0); step(); end
    expect_inst("arst.group", 0, 1, 4, 0, 0, 0);

    // Random traffic against the model on every instance.
    drive(1, 0, 0, 0); step();
    for (int n = 0; n < 400; n++) begin
      int d;
      d = (n % 2 == 1) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, d, 1'($urandom_range(0, 1)));
      step();
      compare_model(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_accum.md
# mac_accum

Accumulation stage that sits directly downstream of the 16x16 signed multiplier. It consumes the multiplier's one-cycle `out`/`done` product pulses and sums each group of LEN consecutive products into a saturating signed accumulator. It presents each completed dot-product on a valid/ready output register. The multiplier has no backpressure, so this block never stalls its input; output overruns are flagged instead.

## Interface
- LEN, default 8: products per result; legal range 1..65535.
- ACC_W, default 40: accumulator and result width in bits; must be at least 32.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush of all state; has priority over every other input.
- in_valid  in  1  product strobe; connects to the multiplier's `done`.
- in_data  in  32  signed product; connects to the multiplier's `out`; sampled only when in_valid=1.
- out_valid  out  1  result available.
- out_data  out  ACC_W  signed result.
- out_sat  out  1  result saturated; qualified by out_valid.
- out_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky; a result was overwritten before it was accepted.
- count  out  16  number of products in the current partial sum.

## Operation
- States:
  - S_IDLE: no partial sum, count=0.
  - S_ACC: partial sum held, 1 ≤ count ≤ LEN-1.
- Per-accepted-product sum: sum = (state==S_IDLE ? 0 : acc) + sign_extend(in_data, ACC_W).
- Saturation:
  - The sum is computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clamp sets the internal sat_acc flag, which stays set for the rest of the group.
- in_valid=1 with count < LEN-1:
  - acc ← sum; count ← count+1; state becomes S_ACC.
- in_valid=1 with count == LEN-1 (group complete):
  - out_data ← sum; out_sat ← sat_acc | this_clamp; out_valid ← 1.
  - acc ← 0; count ← 0; sat_acc ← 0; state becomes S_IDLE.
- LEN=1: every product completes a group and the FSM never leaves S_IDLE.
- in_valid=0: accumulator state holds.
- Output handshake:
  - A result transfers when out_valid & out_ready.
  - After a transfer, out_valid drops next cycle unless a new group completes in the same cycle. In that case out_valid stays 1 and out_data/out_sat take the new result.
  - A group completing while out_valid=1 and out_ready=0 overwrites out_data/out_sat and sets overrun. overrun stays 1 until clear or reset.
  - out_data and out_sat stay stable while out_valid=1 and no transfer occurs, except on an overrun.
- clear=1:
  - acc, count, sat_acc, out_valid, out_sat, out_data and overrun are zeroed; state becomes S_IDLE.
  - An in_valid in the same cycle is discarded.

## Timing
- Reset (reset_n=0, asynchronous) forces: out_valid=0, out_data=0, out_sat=0, overrun=0, count=0, acc=0, state S_IDLE.
- Input acceptance: every cycle; in_valid may be high on consecutive cycles, with one product accepted per cycle.
- Latency: the final product strobed at edge k produces out_valid=1 visible after edge k.
- count output: registered; reflects products accepted up to the previous edge.
- Reset mid-group: the partial sum and any pending result are lost. The first in_valid after reset release starts a new group.
- No combinational path from in_valid or out_ready to any output.

## Test plan
- Basic group, LEN=4, ACC_W=40: products 100, -20, 3, 7 on separate cycles -> out_valid=1 one cycle after the 4th strobe, out_data=90, out_sat=0. Holds until out_ready=1, then out_valid=0 next cycle.
- Back-to-back strobes, LEN=2, out_ready tied 1: products 5,6,7,8 on consecutive cycles -> results 11 then 15, each valid for exactly one cycle; overrun=0.
- Saturation, LEN=4, ACC_W=33: four products 0x40000000 -> out_data=0x0FFFFFFFF, out_sat=1. The next group of 1,1,1,1 gives out_data=4, out_sat=0.
- Overrun, LEN=1, out_ready=0: products 9 then 12 -> out_data=12, overrun=1, out_valid=1. overrun remains 1 after acceptance until clear.
- Clear mid-group, LEN=4: products 1, 2, then clear asserted together with product 3 -> count=0, product 3 discarded. The next four products 1,1,1,1 give out_data=4.
- Async reset, LEN=4: assert reset_n=0 mid-cycle after 2 products with a result pending -> all outputs zero immediately without waiting for a clock edge; the next group starts from count=0.
